// File: rtl/lfu_counter_bank_if.sv
// Request/response bundle between the cache controller and the LFU counter bank.
// The master side issues hits, fills, lookups and flushes; the slave side returns counters and status.
interface lfu_counter_bank_if #(
    parameter int SIZE_COUNTER = 4,
    parameter int NUM_SETS     = 8
);
    localparam int SET_BITS = $clog2(NUM_SETS);

    logic                    hit_valid;
    logic [SET_BITS-1:0]     hit_set;
    logic [3:0]              hit_way;
    logic                    fill_valid;
    logic [SET_BITS-1:0]     fill_set;
    logic [3:0]              fill_way;
    logic                    lookup_req;
    logic [SET_BITS-1:0]     lookup_set;
    logic                    flush;
    logic [SIZE_COUNTER-1:0] count0;
    logic [SIZE_COUNTER-1:0] count1;
    logic [SIZE_COUNTER-1:0] count2;
    logic [SIZE_COUNTER-1:0] count3;
    logic                    count_valid;
    logic                    busy;
    logic                    err;

    modport master (
        output hit_valid, hit_set, hit_way,
        output fill_valid, fill_set, fill_way,
        output lookup_req, lookup_set, flush,
        input  count0, count1, count2, count3, count_valid, busy, err
    );

    modport slave (
        input  hit_valid, hit_set, hit_way,
        input  fill_valid, fill_set, fill_way,
        input  lookup_req, lookup_set, flush,
        output count0, count1, count2, count3, count_valid, busy, err
    );
endinterface

// File: rtl/lfu_counter_bank.sv
// Per-set, per-way saturating use counters feeding an LFU victim comparator.
// Hits count up with set-wide aging at saturation; fills seed a way at 1; flush sweeps one set per cycle.
module lfu_counter_bank #(
    parameter int SIZE_COUNTER = 4,
    parameter int NUM_SETS     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    lfu_counter_bank_if.slave   bus
);
    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam logic [SIZE_COUNTER-1:0] CMAX     = '1;
    localparam logic [SIZE_COUNTER-1:0] ONE      = {{(SIZE_COUNTER-1){1'b0}}, 1'b1};
    // Value a saturated counter takes after aging: (CMAX >> 1) + 1, i.e. only the MSB set.
    localparam logic [SIZE_COUNTER-1:0] AGED_VAL = {1'b1, {(SIZE_COUNTER-1){1'b0}}};
    localparam logic [SET_BITS-1:0]     LAST_SET = SET_BITS'(NUM_SETS - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [SET_BITS-1:0]     ptr;
    logic                    busy;
    logic                    sweep_last;

    logic                    hit_wf;
    logic                    fill_en;
    logic                    hit_en;
    logic                    lookup_en;
    logic                    conflict;
    logic                    req_err;
    logic [1:0]              hit_idx;
    logic [SIZE_COUNTER-1:0] hit_cnt;
    logic                    hit_at_max;

    logic [SIZE_COUNTER-1:0] cnt [NUM_SETS][4];

    assign busy       = (state == FLUSH);
    assign sweep_last = busy && (ptr == LAST_SET);
    assign bus.busy   = busy;

    always_comb begin
        hit_wf    = bus.hit_valid && $onehot(bus.hit_way);
        fill_en   = !busy && bus.fill_valid && $onehot(bus.fill_way);
        conflict  = !busy && hit_wf && fill_en && (bus.hit_set == bus.fill_set);
        hit_en    = !busy && hit_wf && !conflict;
        lookup_en = !busy && bus.lookup_req;
        if (busy) begin
            req_err = bus.hit_valid || bus.fill_valid || bus.lookup_req;
        end else begin
            req_err = (bus.hit_valid && !$onehot(bus.hit_way))
                   || (bus.fill_valid && !$onehot(bus.fill_way))
                   || conflict;
        end
    end

    always_comb begin
        hit_idx = 2'd0;
        case (bus.hit_way)
            4'b0010: hit_idx = 2'd1;
            4'b0100: hit_idx = 2'd2;
            4'b1000: hit_idx = 2'd3;
            default: hit_idx = 2'd0;
        endcase
        hit_cnt    = cnt[bus.hit_set][hit_idx];
        hit_at_max = (hit_cnt == CMAX);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.flush) next_state = FLUSH;
            FLUSH:   if (ptr == LAST_SET) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= busy ? ptr + 1'b1 : '0;
        end
    end

    // Hits and fills never target the same set in one cycle (conflicts drop the hit),
    // so each counter sees at most one of them.
    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        localparam logic [SET_BITS-1:0] SET_ID = SET_BITS'(s);
        for (genvar w = 0; w < 4; w++) begin : g_way
            logic [SIZE_COUNTER-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (busy) begin
                    if (ptr == SET_ID) cnt_q <= '0;
                end else if (fill_en && bus.fill_set == SET_ID && bus.fill_way[w]) begin
                    cnt_q <= ONE;
                end else if (hit_en && bus.hit_set == SET_ID) begin
                    if (hit_at_max) cnt_q <= bus.hit_way[w] ? AGED_VAL : (cnt_q >> 1);
                    else if (bus.hit_way[w]) cnt_q <= cnt_q + 1'b1;
                end
            end

            assign cnt[s][w] = cnt_q;
        end
    end

    // Lookups read the array before this edge's updates land, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.count0      <= '0;
            bus.count1      <= '0;
            bus.count2      <= '0;
            bus.count3      <= '0;
            bus.count_valid <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.count_valid <= lookup_en;
            bus.err         <= req_err;
            if (lookup_en) begin
                bus.count0 <= cnt[bus.lookup_set][0];
                bus.count1 <= cnt[bus.lookup_set][1];
                bus.count2 <= cnt[bus.lookup_set][2];
                bus.count3 <= cnt[bus.lookup_set][3];
            end else if (sweep_last) begin
                bus.count0 <= '0;
                bus.count1 <= '0;
                bus.count2 <= '0;
                bus.count3 <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lfu_counter_bank.sv
// Self-checking bench for lfu_counter_bank: directed scenarios plus a randomized run,
// all checked against a behavioural per-set counter model kept in plain int arrays.
module tb_lfu_counter_bank;
    localparam int W    = 4;
    localparam int NS   = 8;
    localparam int SB   = $clog2(NS);
    localparam int CMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfu_counter_bank_if #(.SIZE_COUNTER(W), .NUM_SETS(NS)) bus ();

    lfu_counter_bank #(.SIZE_COUNTER(W), .NUM_SETS(NS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    int           m [NS][4];
    int           flush_left;
    logic [W-1:0] exp_cnt [4];
    bit           exp_valid;
    bit           exp_err;

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < 4; w++) m[s][w] = 0;
        for (int w = 0; w < 4; w++) exp_cnt[w] = '0;
        flush_left = 0;
        exp_valid  = 0;
        exp_err    = 0;
    endtask

    function automatic int way_index(input logic [3:0] way);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (way[i]) idx = i;
        return idx;
    endfunction

    // One clock edge of the behavioural model, evaluated from the pre-edge model state.
    task automatic model_step(input bit hv, input int hs, input logic [3:0] hw,
                              input bit fv, input int fs, input logic [3:0] fw,
                              input bit lr, input int ls, input bit fl);
        bit hit_ok;
        bit fill_ok;
        int hi;
        exp_err   = 0;
        exp_valid = 0;
        if (flush_left > 0) begin
            if (hv || fv || lr) exp_err = 1;
            for (int w = 0; w < 4; w++) m[NS - flush_left][w] = 0;
            flush_left--;
            if (flush_left == 0)
                for (int w = 0; w < 4; w++) exp_cnt[w] = '0;
        end else begin
            hit_ok  = hv && ($countones(hw) == 1);
            fill_ok = fv && ($countones(fw) == 1);
            if (hv && !hit_ok) exp_err = 1;
            if (fv && !fill_ok) exp_err = 1;
            if (hit_ok && fill_ok && hs == fs) begin
                hit_ok  = 0;
                exp_err = 1;
            end
            if (lr) begin
                for (int w = 0; w < 4; w++) exp_cnt[w] = W'(m[ls][w]);
                exp_valid = 1;
            end
            if (fill_ok) m[fs][way_index(fw)] = 1;
            if (hit_ok) begin
                hi = way_index(hw);
                if (m[hs][hi] == CMAX) begin
                    for (int w = 0; w < 4; w++) m[hs][w] = m[hs][w] / 2;
                    m[hs][hi] = (CMAX + 1) / 2;
                end else begin
                    m[hs][hi] = m[hs][hi] + 1;
                end
            end
            if (fl) flush_left = NS;
        end
    endtask

    // Drives one cycle of requests, advances the model on the edge and returns #1 after it.
    task automatic applyStimulus(input bit hv, input int hs, input logic [3:0] hw,
                                 input bit fv, input int fs, input logic [3:0] fw,
                                 input bit lr, input int ls, input bit fl);
        bus.hit_valid  = hv;
        bus.hit_set    = SB'(hs);
        bus.hit_way    = hw;
        bus.fill_valid = fv;
        bus.fill_set   = SB'(fs);
        bus.fill_way   = fw;
        bus.lookup_req = lr;
        bus.lookup_set = SB'(ls);
        bus.flush      = fl;
        @(posedge clk);
        model_step(hv, hs, hw, fv, fs, fw, lr, ls, fl);
        #1;
    endtask

    task automatic do_idle();
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    endtask

    task automatic do_hit(input int s, input logic [3:0] w);
        applyStimulus(1, s, w, 0, 0, 4'b0000, 0, 0, 0);
    endtask

    task automatic do_fill(input int s, input logic [3:0] w);
        applyStimulus(0, 0, 4'b0000, 1, s, w, 0, 0, 0);
    endtask

    task automatic do_lookup(input int s);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000, 1, s, 0);
    endtask

    task automatic test_reset();
        bus.hit_valid = 0; bus.hit_set = '0; bus.hit_way = '0;
        bus.fill_valid = 0; bus.fill_set = '0; bus.fill_way = '0;
        bus.lookup_req = 0; bus.lookup_set = '0; bus.flush = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid, bus.busy, bus.err} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid, bus.busy, bus.err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_fill(4, 4'b1000);
        do_lookup(4);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid} !==
            {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0], 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL first_edge_fill: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid},
                     {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0], 1'b1});
        end
    endtask

    task automatic test_fill_lookup();
        do_fill(2, 4'b0100);
        do_lookup(2);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid} !== {4'd0, 4'd1, 4'd0, 4'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL fill_lookup: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid}, {4'd0, 4'd1, 4'd0, 4'd0, 1'b1});
        end
        do_idle();
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid} !==
            {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0], 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL count_hold: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid},
                     {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0], 1'b0});
        end
    endtask

    task automatic test_aging();
        do_fill(1, 4'b0001);
        repeat (14) do_hit(1, 4'b0001);
        do_fill(1, 4'b0010);
        repeat (5) do_hit(1, 4'b0010);
        do_fill(1, 4'b0100);
        repeat (2) do_hit(1, 4'b0100);
        do_lookup(1);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0} !== {4'd0, 4'd3, 4'd6, 4'd15}) begin
            miscompares++;
            $display("[TB] FAIL aging_setup: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0}, {4'd0, 4'd3, 4'd6, 4'd15});
        end
        do_hit(1, 4'b0001);
        do_lookup(1);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0} !== {4'd0, 4'd1, 4'd3, 4'd8}) begin
            miscompares++;
            $display("[TB] FAIL aging_result: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0}, {4'd0, 4'd1, 4'd3, 4'd8});
        end
    endtask

    task automatic test_conflict();
        do_fill(3, 4'b0001);
        repeat (2) do_hit(3, 4'b0001);
        applyStimulus(1, 3, 4'b0001, 1, 3, 4'b0010, 0, 0, 0);
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL conflict_err: got %b, expected 1", bus.err);
        end
        do_idle();
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL conflict_err_once: got %b, expected 0", bus.err);
        end
        do_lookup(3);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0} !== {4'd0, 4'd0, 4'd1, 4'd3}) begin
            miscompares++;
            $display("[TB] FAIL conflict_counts: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0}, {4'd0, 4'd0, 4'd1, 4'd3});
        end
    endtask

    task automatic test_malformed();
        applyStimulus(1, 2, 4'b0011, 0, 0, 4'b0000, 0, 0, 0);
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL multi_hot_hit_err: got %b, expected 1", bus.err);
        end
        do_fill(2, 4'b0000);
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL zero_way_fill_err: got %b, expected 1", bus.err);
        end
        do_lookup(2);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.err} !== {4'd0, 4'd1, 4'd0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL malformed_no_change: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.err}, {4'd0, 4'd1, 4'd0, 4'd0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1, 2, 4'b0100, 1, 5, 4'b0001, 1, 2, 0);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.err} !== {4'd0, 4'd1, 4'd0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL read_before_write: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.err}, {4'd0, 4'd1, 4'd0, 4'd0, 1'b0});
        end
        do_lookup(2);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0} !== {4'd0, 4'd2, 4'd0, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL dual_hit_set2: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0}, {4'd0, 4'd2, 4'd0, 4'd0});
        end
        do_lookup(5);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0} !== {4'd0, 4'd0, 4'd0, 4'd1}) begin
            miscompares++;
            $display("[TB] FAIL dual_fill_set5: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0}, {4'd0, 4'd0, 4'd0, 4'd1});
        end
    endtask

    task automatic test_flush();
        int busy_cycles = 0;
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);
        for (int i = 0; i < 2 * NS && bus.busy === 1'b1; i++) begin
            busy_cycles++;
            if (i == 2) begin
                do_lookup(5);
                vectors++;
                if ({bus.err, bus.count_valid} !== 2'b10) begin
                    miscompares++;
                    $display("[TB] FAIL busy_lookup_dropped: err/valid got %b, expected 10", {bus.err, bus.count_valid});
                end
            end else begin
                do_idle();
            end
        end
        vectors++;
        if (busy_cycles !== NS) begin
            miscompares++;
            $display("[TB] FAIL busy_length: got %0d cycles, expected %0d", busy_cycles, NS);
        end
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0} !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_clears_counts: got %h, expected 0",
                     {bus.count3, bus.count2, bus.count1, bus.count0});
        end
        for (int s = 0; s < NS; s++) begin
            do_lookup(s);
            vectors++;
            if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid} !== {16'd0, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL flushed_set%0d: got %h, expected %h", s,
                         {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid}, {16'd0, 1'b1});
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        do_fill(6, 4'b0010);
        do_hit(6, 4'b0010);
        do_lookup(6);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);
        do_idle();
        do_idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid, bus.busy, bus.err} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_mid_flush: got %h, expected 0",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid, bus.busy, bus.err});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_idle();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_release: busy got %b, expected 0", bus.busy);
        end
        do_lookup(6);
        vectors++;
        if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid} !== {16'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_cleared_set6: got %h, expected %h",
                     {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid}, {16'd0, 1'b1});
        end
    endtask

    task automatic test_random();
        logic [3:0] hw;
        logic [3:0] fw;
        for (int n = 0; n < 400; n++) begin
            hw = ($urandom_range(0, 7) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            fw = ($urandom_range(0, 7) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, NS - 1), hw,
                          ($urandom_range(0, 3) == 0), $urandom_range(0, NS - 1), fw,
                          1'($urandom_range(0, 1)), $urandom_range(0, NS - 1),
                          ($urandom_range(0, 59) == 0));
            vectors++;
            if ({bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid, bus.busy, bus.err} !==
                {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0], exp_valid, (flush_left > 0), exp_err}) begin
                miscompares++;
                $display("[TB] FAIL random_cycle%0d: got %h, expected %h", n,
                         {bus.count3, bus.count2, bus.count1, bus.count0, bus.count_valid, bus.busy, bus.err},
                         {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0], exp_valid, (flush_left > 0), exp_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_lookup();
        test_aging();
        test_conflict();
        test_malformed();
        test_back_to_back();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
